// File: rtl/fport_pkg.sv
// rtl/fport_pkg.sv - F.Port protocol constants, parser/UART state encodings and checksum helper.
package fport_pkg;

  localparam logic [7:0] FPORT_DELIM        = 8'h7E;
  localparam logic [7:0] FPORT_ESC          = 8'h7D;
  localparam logic [7:0] FPORT_XOR          = 8'h20;
  localparam logic [7:0] FPORT_LEN          = 8'h19;
  localparam logic [7:0] FPORT_TYPE_CONTROL = 8'h00;
  localparam int         FPORT_DATA_BYTES   = 22;
  localparam int         FPORT_PAYLOAD_BITS = 8 * FPORT_DATA_BYTES;
  localparam int         FLAG_FAILSAFE_BIT  = 3;
  localparam int         FLAG_FRAME_LOST_BIT = 2;

  typedef enum logic [3:0] {
    P_IDLE,
    P_LEN,
    P_TYPE,
    P_DATA,
    P_FLAGS,
    P_RSSI,
    P_CRC,
    P_END,
    P_SKIP
  } parser_state_e;

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } uart_state_e;

  // 8-bit add with end-around carry; 0xFE+1 is the worst case, so no second carry.
  function automatic logic [7:0] sum_eac(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[7:0] + {7'd0, s[8]};
  endfunction

endpackage

// File: rtl/fport_uart_rx.sv
// rtl/fport_uart_rx.sv - Oversampling 8N1 receiver with synchroniser, optional inversion and stop-bit check.
module fport_uart_rx
  import fport_pkg::*;
#(
  parameter int clocks_per_bit = 104,
  parameter int invert_input   = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       fport,
  output logic       byte_valid,
  output logic [7:0] data_byte,
  output logic       framing_error
);

  localparam int   CW       = $clog2(clocks_per_bit);
  localparam int   HALF     = clocks_per_bit / 2;
  localparam logic INV      = (invert_input != 0);
  localparam logic IDLE_PIN = ~INV;

  uart_state_e state_q, state_d;
  logic          meta_q, sync_q, prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          line;

  assign line      = sync_q ^ INV;
  assign data_byte = shift_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q  <= IDLE_PIN;
      sync_q  <= IDLE_PIN;
      prev_q  <= 1'b1;
      state_q <= U_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      meta_q  <= fport;
      sync_q  <= meta_q;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    prev_d        = line;
    byte_valid    = 1'b0;
    framing_error = 1'b0;
    case (state_q)
      U_IDLE: begin
        if (prev_q && !line) begin
          state_d = U_START;
          cnt_d   = '0;
        end
      end
      U_START: begin
        // A glitch shorter than half a bit returns to idle.
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = line ? U_IDLE : U_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      U_DATA: begin
        if (cnt_q == CW'(clocks_per_bit - 1)) begin
          cnt_d   = '0;
          shift_d = {line, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = U_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      U_STOP: begin
        if (cnt_q == CW'(clocks_per_bit - 1)) begin
          state_d       = U_IDLE;
          byte_valid    = line;
          framing_error = !line;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = U_IDLE;
    endcase
  end

endmodule

// File: rtl/fport_receiver.sv
// rtl/fport_receiver.sv - F.Port control-frame receiver: de-stuffing, parsing, checksum, unpack and link timeout.
module fport_receiver
  import fport_pkg::*;
#(
  parameter int clock_frequency = 12000000,
  parameter int fport_baudrate  = 115200,
  parameter int clocks_per_bit  = clock_frequency / fport_baudrate,
  parameter int channel_count   = 16,
  parameter int invert_input    = 1,
  parameter int timeout_clocks  = clock_frequency / 10
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       fport,
  output logic [11*channel_count-1:0] channels,
  output logic [7:0]                 rssi,
  output logic                       failsafe,
  output logic                       frame_lost,
  output logic                       frame_valid,
  output logic                       crc_error,
  output logic [15:0]                crc_error_count,
  output logic                       link_lost
);

  localparam int CHW = 11 * channel_count;
  localparam int TW  = $clog2(timeout_clocks + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(timeout_clocks);

  logic       byte_valid, framing_error;
  logic [7:0] data_byte;

  fport_uart_rx #(
    .clocks_per_bit(clocks_per_bit),
    .invert_input  (invert_input)
  ) u_uart (
    .clock        (clock),
    .reset_n      (reset_n),
    .fport        (fport),
    .byte_valid   (byte_valid),
    .data_byte    (data_byte),
    .framing_error(framing_error)
  );

  parser_state_e                 state_q, state_d;
  logic                          esc_q, esc_d;
  logic [4:0]                    cnt_q, cnt_d;
  logic [7:0]                    sum_q, sum_d;
  logic [FPORT_PAYLOAD_BITS-1:0] data_q, data_d;
  logic [7:0]                    flags_q, flags_d;
  logic [7:0]                    rssi_buf_q, rssi_buf_d;
  logic [CHW-1:0]                channels_q, channels_d;
  logic [7:0]                    rssi_q, rssi_d;
  logic                          failsafe_q, failsafe_d;
  logic                          frame_lost_q, frame_lost_d;
  logic                          frame_valid_q, frame_valid_d;
  logic                          crc_error_q, crc_error_d;
  logic [15:0]                   err_cnt_q, err_cnt_d;
  logic [TW-1:0]                 tmo_q, tmo_d;
  logic                          link_lost_q, link_lost_d;

  logic       is_delim, is_data, in_frame, commit, reject;
  logic [7:0] val, sum_add;
  logic       unused_bits;

  assign is_delim = byte_valid && !esc_q && (data_byte == FPORT_DELIM);
  assign is_data  = byte_valid && (esc_q || ((data_byte != FPORT_DELIM) && (data_byte != FPORT_ESC)));
  assign val      = esc_q ? (data_byte ^ FPORT_XOR) : data_byte;
  assign sum_add  = sum_eac(sum_q, val);
  assign in_frame = (state_q != P_IDLE) && (state_q != P_LEN) && (state_q != P_END);
  assign unused_bits = ^{data_q, flags_q};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= P_IDLE;
      esc_q         <= 1'b0;
      cnt_q         <= '0;
      sum_q         <= '0;
      data_q        <= '0;
      flags_q       <= '0;
      rssi_buf_q    <= '0;
      channels_q    <= '0;
      rssi_q        <= '0;
      failsafe_q    <= 1'b0;
      frame_lost_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      crc_error_q   <= 1'b0;
      err_cnt_q     <= '0;
      tmo_q         <= '0;
      link_lost_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      esc_q         <= esc_d;
      cnt_q         <= cnt_d;
      sum_q         <= sum_d;
      data_q        <= data_d;
      flags_q       <= flags_d;
      rssi_buf_q    <= rssi_buf_d;
      channels_q    <= channels_d;
      rssi_q        <= rssi_d;
      failsafe_q    <= failsafe_d;
      frame_lost_q  <= frame_lost_d;
      frame_valid_q <= frame_valid_d;
      crc_error_q   <= crc_error_d;
      err_cnt_q     <= err_cnt_d;
      tmo_q         <= tmo_d;
      link_lost_q   <= link_lost_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    esc_d      = esc_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    data_d     = data_q;
    flags_d    = flags_q;
    rssi_buf_d = rssi_buf_q;
    commit     = 1'b0;
    reject     = 1'b0;
    if (framing_error) begin
      state_d = P_IDLE;
      esc_d   = 1'b0;
    end else if (byte_valid) begin
      esc_d = !esc_q && (data_byte == FPORT_ESC);
      if (is_delim && in_frame) begin
        state_d = P_LEN;
      end else begin
        case (state_q)
          P_IDLE: if (is_delim) state_d = P_LEN;
          P_LEN: begin
            if (is_data) begin
              state_d = (val == FPORT_LEN) ? P_TYPE : P_IDLE;
              sum_d   = val;
            end
          end
          P_TYPE: begin
            if (is_data) begin
              sum_d   = sum_add;
              cnt_d   = '0;
              state_d = (val == FPORT_TYPE_CONTROL) ? P_DATA : P_SKIP;
            end
          end
          P_DATA: begin
            if (is_data) begin
              // First byte ends up in bits [7:0]: little-endian payload word.
              sum_d  = sum_add;
              data_d = {val, data_q[FPORT_PAYLOAD_BITS-1:8]};
              cnt_d  = cnt_q + 5'd1;
              if (cnt_q == 5'(FPORT_DATA_BYTES - 1)) state_d = P_FLAGS;
            end
          end
          P_FLAGS: begin
            if (is_data) begin
              sum_d   = sum_add;
              flags_d = val;
              state_d = P_RSSI;
            end
          end
          P_RSSI: begin
            if (is_data) begin
              sum_d      = sum_add;
              rssi_buf_d = val;
              state_d    = P_CRC;
            end
          end
          P_CRC: begin
            if (is_data) begin
              sum_d   = sum_add;
              state_d = P_END;
            end
          end
          P_END: begin
            if (is_delim) begin
              commit  = (sum_q == 8'hFF);
              reject  = (sum_q != 8'hFF);
              state_d = P_LEN;
            end else if (is_data) begin
              state_d = P_IDLE;
            end
          end
          P_SKIP: begin
            // Remaining length bytes after TYPE plus the checksum byte.
            if (is_data) begin
              cnt_d = cnt_q + 5'd1;
              if (cnt_q == 5'(FPORT_LEN - 8'd1)) state_d = P_IDLE;
            end
          end
          default: state_d = P_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    channels_d    = commit ? data_q[CHW-1:0] : channels_q;
    rssi_d        = commit ? rssi_buf_q : rssi_q;
    failsafe_d    = commit ? flags_q[FLAG_FAILSAFE_BIT] : failsafe_q;
    frame_lost_d  = commit ? flags_q[FLAG_FRAME_LOST_BIT] : frame_lost_q;
    frame_valid_d = commit;
    crc_error_d   = reject;
    err_cnt_d     = (reject && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;
    tmo_d         = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TW'(1);
    link_lost_d   = link_lost_q || (tmo_d == TMO_MAX);
    if (commit) begin
      tmo_d       = '0;
      link_lost_d = 1'b0;
    end
  end

  assign channels        = channels_q;
  assign rssi            = rssi_q;
  assign failsafe        = failsafe_q;
  assign frame_lost      = frame_lost_q;
  assign frame_valid     = frame_valid_q;
  assign crc_error       = crc_error_q;
  assign crc_error_count = err_cnt_q;
  assign link_lost       = link_lost_q;

endmodule

// File: tb/tb_fport_receiver.sv
// tb/tb_fport_receiver.sv - Directed self-checking bench for fport_receiver.
module tb_fport_receiver;

  localparam int CLK_HZ = 800000;
  localparam int BAUD   = 100000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int TMO    = 3000;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic fport = 1'b0;

  logic [175:0] channels;
  logic [7:0]   rssi;
  logic         failsafe, frame_lost, frame_valid, crc_error, link_lost;
  logic [15:0]  crc_error_count;
  logic [43:0]  channels4;
  logic [7:0]   rssi4;
  logic         failsafe4, frame_lost4, frame_valid4, crc_error4, link_lost4;
  logic [15:0]  crc_error_count4;

  always #5 clock = ~clock;

  fport_receiver #(
    .clock_frequency(CLK_HZ), .fport_baudrate(BAUD), .clocks_per_bit(CPB),
    .channel_count(16), .invert_input(1), .timeout_clocks(TMO)
  ) dut (
    .clock(clock), .reset_n(reset_n), .fport(fport), .channels(channels), .rssi(rssi),
    .failsafe(failsafe), .frame_lost(frame_lost), .frame_valid(frame_valid),
    .crc_error(crc_error), .crc_error_count(crc_error_count), .link_lost(link_lost)
  );

  fport_receiver #(
    .clock_frequency(CLK_HZ), .fport_baudrate(BAUD), .clocks_per_bit(CPB),
    .channel_count(4), .invert_input(1), .timeout_clocks(TMO)
  ) dut4 (
    .clock(clock), .reset_n(reset_n), .fport(fport), .channels(channels4), .rssi(rssi4),
    .failsafe(failsafe4), .frame_lost(frame_lost4), .frame_valid(frame_valid4),
    .crc_error(crc_error4), .crc_error_count(crc_error_count4), .link_lost(link_lost4)
  );

  int vectors = 0;
  int miscompares = 0;
  int fv_cnt = 0;
  int ce_cnt = 0;
  int unstable = 0;
  longint fv_time = 0;
  longint ce_time = 0;
  longint stop_center = 0;
  logic [175:0] prev_ch = '0;

  logic [10:0] tx_ch [16];
  logic [7:0]  tx_flags, tx_rssi;

  always @(negedge clock) begin
    if (frame_valid) begin fv_cnt++; fv_time = $time; end
    if (crc_error) begin ce_cnt++; ce_time = $time; end
    if (reset_n && !frame_valid && (channels !== prev_ch)) unstable++;
    prev_ch = channels;
  end

  function automatic logic [7:0] eac(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[7:0] + {7'd0, s[8]};
  endfunction

  // Pin is inverted: logical 1 drives 0.
  task automatic send_raw(input logic [7:0] b);
    fport = 1'b1;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      fport = ~b[i];
      repeat (CPB) @(negedge clock);
    end
    stop_center = $time + 64'(CPB * 5);
    fport = 1'b0;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_data(input logic [7:0] b);
    if (b == 8'h7E || b == 8'h7D) begin
      send_raw(8'h7D);
      send_raw(b ^ 8'h20);
    end else begin
      send_raw(b);
    end
  endtask

  task automatic send_frame(input logic [7:0] crc_delta);
    logic [175:0] w;
    logic [7:0]   s, bt;
    w = '0;
    for (int k = 0; k < 16; k++) w[11*k +: 11] = tx_ch[k];
    send_raw(8'h7E);
    s = 8'h19;
    send_data(8'h19);
    s = eac(s, 8'h00);
    send_data(8'h00);
    for (int i = 0; i < 22; i++) begin
      bt = w[8*i +: 8];
      s = eac(s, bt);
      send_data(bt);
    end
    s = eac(s, tx_flags);
    send_data(tx_flags);
    s = eac(s, tx_rssi);
    send_data(tx_rssi);
    send_data((~s) + crc_delta);
    send_raw(8'h7E);
  endtask

  task automatic test_reset();
    vectors++; if (channels !== '0) begin miscompares++; $display("FAIL reset_channels got %h want 0", channels); end
    vectors++; if (channels4 !== '0) begin miscompares++; $display("FAIL reset_channels4 got %h want 0", channels4); end
    vectors++; if (rssi !== 8'h00) begin miscompares++; $display("FAIL reset_rssi got %h want 00", rssi); end
    vectors++; if (link_lost !== 1'b1) begin miscompares++; $display("FAIL reset_link_lost got %b want 1", link_lost); end
    vectors++; if (crc_error_count !== 16'd0) begin miscompares++; $display("FAIL reset_crc_count got %0d want 0", crc_error_count); end
    vectors++; if ({frame_valid, crc_error, failsafe, frame_lost} !== 4'b0) begin
      miscompares++; $display("FAIL reset_flags got %b want 0000", {frame_valid, crc_error, failsafe, frame_lost});
    end
  endtask

  task automatic test_good_frame();
    int fv0;
    longint lat;
    for (int k = 0; k < 16; k++) tx_ch[k] = 11'd992;
    tx_flags = 8'h00; tx_rssi = 8'h64;
    fv0 = fv_cnt;
    send_frame(8'd0);
    repeat (2) @(negedge clock);
    vectors++; if (fv_cnt - fv0 !== 1) begin miscompares++; $display("FAIL good_fv_count got %0d want 1", fv_cnt - fv0); end
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (channels[11*k +: 11] !== 11'd992) begin
        miscompares++; $display("FAIL good_ch%0d got %0d want 992", k, channels[11*k +: 11]);
      end
    end
    vectors++; if (rssi !== 8'h64) begin miscompares++; $display("FAIL good_rssi got %h want 64", rssi); end
    vectors++; if (link_lost !== 1'b0) begin miscompares++; $display("FAIL good_link_lost got %b want 0", link_lost); end
    lat = fv_time - stop_center;
    vectors++; if (lat < 20 || lat > 30) begin miscompares++; $display("FAIL good_latency got %0d want 20..30", lat); end
  endtask

  task automatic test_crc_error();
    int fv0, ce0;
    longint lat;
    fv0 = fv_cnt; ce0 = ce_cnt;
    send_frame(8'd1);
    repeat (2) @(negedge clock);
    vectors++; if (ce_cnt - ce0 !== 1) begin miscompares++; $display("FAIL crc_pulse got %0d want 1", ce_cnt - ce0); end
    vectors++; if (fv_cnt - fv0 !== 0) begin miscompares++; $display("FAIL crc_no_fv got %0d want 0", fv_cnt - fv0); end
    vectors++; if (crc_error_count !== 16'd1) begin miscompares++; $display("FAIL crc_count got %0d want 1", crc_error_count); end
    vectors++; if (channels !== {16{11'd992}}) begin miscompares++; $display("FAIL crc_hold_channels got %h", channels); end
    vectors++; if (rssi !== 8'h64) begin miscompares++; $display("FAIL crc_hold_rssi got %h want 64", rssi); end
    lat = ce_time - stop_center;
    vectors++; if (lat < 20 || lat > 30) begin miscompares++; $display("FAIL crc_latency got %0d want 20..30", lat); end
  endtask

  task automatic test_stuffing();
    int fv0;
    tx_ch[0] = 11'd126;
    tx_rssi = 8'h7D;
    fv0 = fv_cnt;
    send_frame(8'd0);
    repeat (2) @(negedge clock);
    vectors++; if (fv_cnt - fv0 !== 1) begin miscompares++; $display("FAIL stuff_fv got %0d want 1", fv_cnt - fv0); end
    vectors++; if (channels[10:0] !== 11'd126) begin miscompares++; $display("FAIL stuff_ch0 got %0d want 126", channels[10:0]); end
    vectors++; if (channels[21:11] !== 11'd992) begin miscompares++; $display("FAIL stuff_ch1 got %0d want 992", channels[21:11]); end
    vectors++; if (rssi !== 8'h7D) begin miscompares++; $display("FAIL stuff_rssi got %h want 7d", rssi); end
  endtask

  task automatic test_channel_count();
    for (int k = 0; k < 16; k++) tx_ch[k] = 11'(100 * k);
    tx_flags = 8'h08; tx_rssi = 8'h50;
    send_frame(8'd0);
    repeat (2) @(negedge clock);
    vectors++; if (channels4 !== {11'd300, 11'd200, 11'd100, 11'd0}) begin
      miscompares++; $display("FAIL cc4_channels got %h want %h", channels4, {11'd300, 11'd200, 11'd100, 11'd0});
    end
    vectors++; if (channels[175:165] !== 11'd1500) begin miscompares++; $display("FAIL cc16_ch15 got %0d want 1500", channels[175:165]); end
    vectors++; if ({failsafe, frame_lost} !== 2'b10) begin miscompares++; $display("FAIL flags_08 got %b want 10", {failsafe, frame_lost}); end
    vectors++; if (rssi4 !== 8'h50) begin miscompares++; $display("FAIL cc4_rssi got %h want 50", rssi4); end
  endtask

  task automatic test_timeout();
    int fv0;
    for (int k = 0; k < 16; k++) tx_ch[k] = 11'd500;
    tx_flags = 8'h04; tx_rssi = 8'h33;
    send_frame(8'd0);
    #(fv_time + 64'(10 * (TMO - 1)) - $time);
    vectors++; if (link_lost !== 1'b0) begin miscompares++; $display("FAIL tmo_early got %b want 0", link_lost); end
    #10;
    vectors++; if (link_lost !== 1'b1) begin miscompares++; $display("FAIL tmo_exact got %b want 1", link_lost); end
    vectors++; if (channels !== {16{11'd500}}) begin miscompares++; $display("FAIL tmo_hold_channels got %h", channels); end
    vectors++; if ({failsafe, frame_lost} !== 2'b01) begin miscompares++; $display("FAIL tmo_hold_flags got %b want 01", {failsafe, frame_lost}); end
    tx_flags = 8'h00;
    fv0 = fv_cnt;
    send_frame(8'd0);
    repeat (2) @(negedge clock);
    vectors++; if (fv_cnt - fv0 !== 1) begin miscompares++; $display("FAIL tmo_recover_fv got %0d want 1", fv_cnt - fv0); end
    vectors++; if (link_lost !== 1'b0) begin miscompares++; $display("FAIL tmo_recover got %b want 0", link_lost); end
  endtask

  task automatic test_reset_mid_frame();
    int fv0;
    send_raw(8'h7E);
    send_data(8'h19);
    send_data(8'h00);
    for (int i = 0; i < 5; i++) send_data(8'h11);
    fport = 1'b1;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 3; i++) begin fport = i[0]; repeat (CPB) @(negedge clock); end
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    vectors++; if (channels !== '0 || channels4 !== '0) begin miscompares++; $display("FAIL rst_mid_channels got %h / %h want 0", channels, channels4); end
    vectors++; if ({rssi, failsafe, frame_lost, frame_valid} !== 11'd0) begin
      miscompares++; $display("FAIL rst_mid_regs got %h want 0", {rssi, failsafe, frame_lost, frame_valid});
    end
    vectors++; if (link_lost !== 1'b1) begin miscompares++; $display("FAIL rst_mid_link got %b want 1", link_lost); end
    vectors++; if (crc_error_count !== 16'd0) begin miscompares++; $display("FAIL rst_mid_crc_count got %0d want 0", crc_error_count); end
    fport = 1'b0;
    repeat (5) @(negedge clock);
    #2 reset_n = 1'b1;
    repeat (20) @(negedge clock);
    for (int k = 0; k < 16; k++) tx_ch[k] = 11'(64 * k + 7);
    tx_flags = 8'h00; tx_rssi = 8'h21;
    fv0 = fv_cnt;
    send_frame(8'd0);
    repeat (2) @(negedge clock);
    vectors++; if (fv_cnt - fv0 !== 1) begin miscompares++; $display("FAIL rst_after_fv got %0d want 1", fv_cnt - fv0); end
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (channels[11*k +: 11] !== 11'(64 * k + 7)) begin
        miscompares++; $display("FAIL rst_after_ch%0d got %0d want %0d", k, channels[11*k +: 11], 64 * k + 7);
      end
    end
    vectors++; if (rssi !== 8'h21 || link_lost !== 1'b0) begin
      miscompares++; $display("FAIL rst_after_rssi_link got %h/%b want 21/0", rssi, link_lost);
    end
  endtask

  initial begin
    repeat (4) @(negedge clock);
    test_reset();
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    test_good_frame();
    test_crc_error();
    test_stuffing();
    test_channel_count();
    test_timeout();
    test_reset_mid_frame();
    vectors++;
    if (unstable !== 0) begin miscompares++; $display("FAIL output_stability got %0d changes want 0", unstable); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
